rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV64I datapath: register file, single ALU, immediate extender, and a shared instruction/data memory port.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables.
- Runs the memory request/ready handshake and counts retired instructions.
- Traps on an illegal opcode or a memory timeout.

Parameters:
- TIMEOUT, 16: max consecutive cycles waiting for mem_ready before trapping (>=2).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- funct3  in  3  IR[14:12].
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed rs1 < rs2.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (store), 0 = read.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  latch IR and old_pc.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- alu_a  out  1  0 = PC/old_pc, 1 = rs1.
- alu_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate.
- alu_op  out  2  0 = add, 1 = sub/compare, 2 = funct-decoded.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- retired  out  CNT_W  retired-instruction count.
- trap  out  1  sticky error.
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; retired=0, trap=0, trap_cause=0, wait counter=0.
  - All outputs are 0 in IDLE.
  - IDLE -> FETCH unconditionally on the first clock edge after release.
- FETCH:
  - Drives mem_req=1, iord=0, alu_a=0, alu_b=1, alu_op=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
  - Otherwise stays in FETCH and increments the wait counter.
- DECODE:
  - Computes the branch target old_pc+imm into ALUOut: alu_a=0, alu_b=2, alu_op=0.
  - Next state by opcode:
    - 0110011 -> EXEC_R.
    - 0010011 -> EXEC_I.
    - 0000011 or 0100011 -> MEM_ADDR.
    - 1100011 -> BRANCH.
    - Any other opcode -> TRAP with cause 1.
- EXEC_R: alu_a=1, alu_b=0, alu_op=2 -> WB_ALU.
- EXEC_I: alu_a=1, alu_b=2, alu_op=2 -> WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, retire -> FETCH.
- MEM_ADDR: alu_a=1, alu_b=2, alu_op=0. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_req=1, iord=1, mem_we=0. On mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, retire -> FETCH.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready: retire -> FETCH.
- BRANCH:
  - alu_a=1, alu_b=0, alu_op=1; retire -> FETCH.
  - Taken condition by funct3:
    - 000 (beq): alu_zero.
    - 001 (bne): !alu_zero.
    - 100 (blt): alu_lt.
    - 101 (bge): !alu_lt.
  - Taken: pc_write=1, pc_src=1. This is the only output that depends on the flags (Mealy).
  - Any other funct3 -> TRAP with cause 1, no retire.
- Latency with zero-wait memory:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each cycle with mem_ready=0 adds one cycle.
- Handshake:
  - mem_req, iord and mem_we stay stable while mem_ready=0.
  - mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
  - Completion happens in the same cycle mem_ready is seen.
- Wait counter:
  - Clears on every state change.
  - When it reaches TIMEOUT-1 with mem_ready still 0 -> TRAP with cause 2 (trap after TIMEOUT unready cycles).
  - mem_ready=1 on that same cycle wins: the access completes normally.
- Retire: retired += 1 on the cycle the instruction leaves its final state. It wraps modulo 2^CNT_W.
- TRAP:
  - trap=1, all enables 0, mem_req=0.
  - trap_cause holds the first cause.
  - Remains in TRAP until reset.
- Reset mid-operation (including mid-handshake): immediate return to IDLE. No partial write enable is asserted after reset falls.

Test Plan:
- Zero-wait stream: addi, add, ld, sd, beq with mem_ready tied 1 -> cycle counts 4/4/5/4/3; retired=5; reg_write pulses only in WB_ALU and MEM_WB.
- Branch: beq with alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH. bne with alu_zero=1 -> pc_write=0. Both retire.
- Fetch wait: mem_ready low for 3 cycles -> FETCH held 4 cycles with stable mem_req=1, iord=0; ir_write only on the 4th cycle.
- Timeout: TIMEOUT=16, mem_ready held 0 in MEM_RD -> trap=1, trap_cause=2 after 16 unready cycles; outputs zero thereafter.
- Illegal: opcode 1111111 in DECODE -> TRAP, cause 1, retired unchanged.
- Async reset asserted in MEM_WR with mem_ready=0 -> state IDLE immediately, mem_req=0, retired=0; FETCH one cycle after release.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv_multicycle_ctrl
// Description : Main control FSM for a multi-cycle RV64I datapath with a
//               shared memory port, request/ready handshake and trap logic.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_a,
    output logic [1:0]       alu_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [CNT_W-1:0] retired,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam int                  c_WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]    r_retired;
    logic [1:0]          r_trap_cause;
    logic                w_retire;
    logic [1:0]          w_cause;
    logic                w_timeout;
    logic                w_taken;
    logic                w_br_legal;

    // The final unready cycle traps only if mem_ready is still low on it.
    assign w_timeout = (r_wait == c_WAIT_LAST) && !mem_ready;

    always_comb begin
        w_taken    = 1'b0;
        w_br_legal = 1'b1;
        case (funct3)
            3'b000:  w_taken = alu_zero;
            3'b001:  w_taken = !alu_zero;
            3'b100:  w_taken = alu_lt;
            3'b101:  w_taken = !alu_lt;
            default: w_br_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_retired    <= '0;
            r_trap_cause <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (mem_req && !mem_ready)
                r_wait <= r_wait + 1'b1;
            if (w_retire)
                r_retired <= r_retired + 1'b1;
            if ((r_state != S_TRAP) && (w_next == S_TRAP))
                r_trap_cause <= w_cause;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_cause    = 2'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_a      = 1'b0;
        alu_b      = 2'd0;
        alu_op     = 2'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                alu_b   = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_cause = c_CAUSE_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_b = 2'd2;
                case (opcode)
                    c_OP_R:                w_next = S_EXEC_R;
                    c_OP_I:                w_next = S_EXEC_I;
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEM_ADDR;
                    c_OP_BRANCH:           w_next = S_BRANCH;
                    default: begin
                        w_cause = c_CAUSE_ILLEGAL;
                        w_next  = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_a  = 1'b1;
                alu_op = 2'd2;
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_a  = 1'b1;
                alu_b  = 2'd2;
                alu_op = 2'd2;
                w_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_a  = 1'b1;
                alu_b  = 2'd2;
                // opcode bit 5 separates store (0100011) from load (0000011)
                w_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    w_cause = c_CAUSE_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_timeout) begin
                    w_cause = c_CAUSE_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end
            S_BRANCH: begin
                alu_a  = 1'b1;
                alu_op = 2'd1;
                if (w_br_legal) begin
                    pc_write = w_taken;
                    pc_src   = w_taken;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_cause = c_CAUSE_ILLEGAL;
                    w_next  = S_TRAP;
                end
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    assign retired    = r_retired;
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_trap_cause;

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_multicycle_ctrl
// Description : Self-checking bench for rv_multicycle_ctrl using an
//               instruction-level reference model and directed corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_multicycle_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam int C_R  = 0;
    localparam int C_I  = 1;
    localparam int C_LD = 2;
    localparam int C_SD = 3;
    localparam int C_BR = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             alu_zero;
    logic             alu_lt;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             alu_a;
    logic [1:0]       alu_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             mem_to_reg;
    logic [CNT_W-1:0] retired;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [12:0]      ctl;

    int checks       = 0;
    int errors       = 0;
    int exp_retired  = 0;

    rv_multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .retired(retired), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_a,
                  alu_b, alu_op, reg_write, mem_to_reg};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_LD:    return 7'b0000011;
            C_SD:    return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input logic z, input logic lt);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt;
            default: return !lt;
        endcase
    endfunction

    // Holds reset, checks the quiescent outputs, releases and expects FETCH.
    task automatic do_reset();
        reset     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 7'd0;
        repeat (2) next_cycle();
        chk("reset_ctl", ctl, 0);
        chk("reset_retired", retired, 0);
        chk("reset_trap", {trap, trap_cause}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_ctl", ctl, 0);
        next_cycle();
        chk("first_fetch", {mem_req, iord, alu_b}, {1'b1, 1'b0, 2'd1});
        exp_retired = 0;
    endtask

    // Runs one legal instruction from FETCH and checks its aggregate profile.
    task automatic run_instr(input int cls, input logic [2:0] f3, input logic z,
                             input logic lt, input int fw, input int mw);
        int n, fl, ml;
        int rw, m2r, we, pcw, pcs, irw, req, io;
        bit taken, is_mem;
        opcode   = op_of(cls);
        funct3   = f3;
        alu_zero = z;
        alu_lt   = lt;
        is_mem   = (cls == C_LD) || (cls == C_SD);
        taken    = (cls == C_BR) && br_taken(f3, z, lt);
        case (cls)
            C_LD:    n = 5 + fw + mw;
            C_SD:    n = 4 + fw + mw;
            C_BR:    n = 3 + fw;
            default: n = 4 + fw;
        endcase
        fl = fw; ml = mw;
        rw = 0; m2r = 0; we = 0; pcw = 0; pcs = 0; irw = 0; req = 0; io = 0;
        for (int c = 0; c < n; c++) begin
            if (mem_req) begin
                if (iord ? (ml > 0) : (fl > 0)) begin
                    mem_ready = 1'b0;
                    if (iord) ml--; else fl--;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            rw  += int'(reg_write);
            m2r += int'(mem_to_reg);
            we  += int'(mem_we);
            pcw += int'(pc_write);
            pcs += int'(pc_src);
            irw += int'(ir_write);
            req += int'(mem_req);
            io  += int'(iord);
            next_cycle();
        end
        exp_retired++;
        chk("reg_write_cnt", rw, (cls == C_SD || cls == C_BR) ? 0 : 1);
        chk("mem_to_reg_cnt", m2r, (cls == C_LD) ? 1 : 0);
        chk("mem_we_cnt", we, (cls == C_SD) ? mw + 1 : 0);
        chk("pc_write_cnt", pcw, taken ? 2 : 1);
        chk("pc_src_cnt", pcs, taken ? 1 : 0);
        chk("ir_write_cnt", irw, 1);
        chk("mem_req_cnt", req, 1 + fw + (is_mem ? 1 + mw : 0));
        chk("iord_cnt", io, is_mem ? 1 + mw : 0);
        chk("back_to_fetch", {mem_req, iord, mem_we, alu_b, trap}, {3'b100, 2'd1, 1'b0});
        chk("retired", retired, exp_retired);
    endtask

    initial begin
        logic [2:0] br_f3 [4];
        br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101};
        funct3   = 3'd0;
        alu_zero = 1'b0;
        alu_lt   = 1'b0;

        do_reset();

        // Zero-wait stream: addi, add, ld, sd, beq (taken)
        run_instr(C_I,  3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(C_R,  3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(C_LD, 3'b011, 1'b0, 1'b0, 0, 0);
        run_instr(C_SD, 3'b011, 1'b0, 1'b0, 0, 0);
        run_instr(C_BR, 3'b000, 1'b1, 1'b0, 0, 0);
        chk("stream_retired", retired, 5);

        // bne with zero flag set is not taken; fetch held by three waits
        run_instr(C_BR, 3'b001, 1'b1, 1'b0, 0, 0);
        run_instr(C_R,  3'b000, 1'b0, 1'b0, 3, 0);

        // Longest wait that still completes on the last allowed cycle
        run_instr(C_LD, 3'b011, 1'b0, 1'b0, TIMEOUT - 1, TIMEOUT - 1);
        run_instr(C_SD, 3'b011, 1'b0, 1'b0, 0, TIMEOUT - 1);

        for (int k = 0; k < 40; k++) begin
            int cls;
            logic [2:0] f3;
            cls = $urandom_range(0, 4);
            f3  = (cls == C_BR) ? br_f3[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
            run_instr(cls, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Illegal opcode: trap with cause 1, retired count frozen
        opcode    = 7'b1111111;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        chk("illegal_trap", {trap, trap_cause}, {1'b1, 2'd1});
        chk("illegal_ctl", ctl, 0);
        chk("illegal_retired", retired, exp_retired);
        opcode = 7'b0110011;
        repeat (3) next_cycle();
        chk("trap_sticky", {trap, trap_cause, ctl}, {1'b1, 2'd1, 13'd0});

        // Async reset in the middle of a store handshake
        do_reset();
        run_instr(C_R, 3'b000, 1'b0, 1'b0, 0, 0);
        opcode    = 7'b0100011;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("mem_wr_active", {mem_req, iord, mem_we}, 3'b111);
        #2;
        reset = 1'b0;
        #1;
        chk("async_ctl", ctl, 0);
        chk("async_retired", retired, 0);
        next_cycle();
        chk("held_ctl", ctl, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_idle", ctl, 0);
        next_cycle();
        chk("release_fetch", {mem_req, iord, alu_b}, {1'b1, 1'b0, 2'd1});
        exp_retired = 0;

        // Memory timeout on a load
        opcode    = 7'b0000011;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
        repeat (TIMEOUT - 1) next_cycle();
        chk("pre_timeout", {mem_req, iord, trap}, 3'b110);
        next_cycle();
        chk("timeout_trap", {trap, trap_cause}, {1'b1, 2'd2});
        chk("timeout_ctl", ctl, 0);
        chk("timeout_retired", retired, 0);

        // Undefined branch funct3: no pc update, trap cause 1
        do_reset();
        opcode    = 7'b1100011;
        funct3    = 3'b010;
        alu_zero  = 1'b1;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("bad_br_pc_write", {pc_write, pc_src}, 2'b00);
        next_cycle();
        chk("bad_br_trap", {trap, trap_cause}, {1'b1, 2'd1});
        chk("bad_br_retired", retired, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
